alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// One op in flight at a time: IDLE (accept) -> EXEC (sample ALU) -> RESP (hold until consumed).
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 5
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iReqValid0,
    input  logic              iReqValid1,
    output logic              oReqReady0,
    output logic              oReqReady1,
    input  logic [CTRL_W-1:0] iReqControl0,
    input  logic [CTRL_W-1:0] iReqControl1,
    input  logic [DATA_W-1:0] iReqA0,
    input  logic [DATA_W-1:0] iReqA1,
    input  logic [DATA_W-1:0] iReqB0,
    input  logic [DATA_W-1:0] iReqB1,
    output logic              oRspValid0,
    output logic              oRspValid1,
    input  logic              iRspReady0,
    input  logic              iRspReady1,
    output logic [DATA_W-1:0] oRspResult0,
    output logic [DATA_W-1:0] oRspResult1,
    output logic              oRspErr0,
    output logic              oRspErr1,
    output logic [CTRL_W-1:0] oAluControl,
    output logic [DATA_W-1:0] oAluA,
    output logic [DATA_W-1:0] oAluB,
    input  logic [DATA_W-1:0] iAluResult,
    output logic              oBusy
);

    localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(5'b00000);
    localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(5'b00001);
    localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(5'b00010);
    localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(5'b00110);
    localparam logic [CTRL_W-1:0] OP_SLT = CTRL_W'(5'b00111);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                owner_q, owner_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                err_q, err_d;

    logic winner;
    logic any_valid;
    logic op_legal;
    logic rsp_ready;

    // Contested grant goes to whoever did not win last; a lone requester always wins.
    assign any_valid = iReqValid0 | iReqValid1;
    assign winner    = (iReqValid0 && iReqValid1) ? !last_grant_q : iReqValid1;
    assign rsp_ready = owner_q ? iRspReady1 : iRspReady0;
    assign op_legal  = (ctrl_q == OP_AND) || (ctrl_q == OP_OR) || (ctrl_q == OP_ADD) ||
                       (ctrl_q == OP_SUB) || (ctrl_q == OP_SLT);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            ctrl_q       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            ctrl_q       <= ctrl_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        ctrl_d       = ctrl_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d      = EXEC;
                    owner_d      = winner;
                    last_grant_d = winner;
                    ctrl_d       = winner ? iReqControl1 : iReqControl0;
                    a_d          = winner ? iReqA1 : iReqA0;
                    b_d          = winner ? iReqB1 : iReqB0;
                end
            end
            EXEC: begin
                // Illegal ops never let the ALU output through.
                state_d  = RESP;
                result_d = op_legal ? iAluResult : '0;
                err_d    = !op_legal;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        oReqReady0  = 1'b0;
        oReqReady1  = 1'b0;
        oRspValid0  = 1'b0;
        oRspValid1  = 1'b0;
        oRspResult0 = result_q;
        oRspResult1 = result_q;
        oRspErr0    = err_q;
        oRspErr1    = err_q;
        oAluControl = ctrl_q;
        oAluA       = a_q;
        oAluB       = b_q;
        oBusy       = (state_q != IDLE);
        if (state_q == IDLE && any_valid) begin
            oReqReady0 = !winner;
            oReqReady1 = winner;
        end
        if (state_q == RESP) begin
            oRspValid0 = !owner_q;
            oRspValid1 = owner_q;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, directed multi-cycle sequences, then random traffic
// checked against a transaction-level model of the round-robin/latency rules.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  v, rr;
    logic [4:0]  c [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic        rdy0, rdy1, rv0, rv1, e0, e1, busy;
    logic [31:0] res0, res1, alu_a, alu_b, alu_r;
    logic [4:0]  alu_c;
    logic [1:0]  rdy, rv;
    int          total = 0;
    int          bad = 0;

    assign rdy = {rdy1, rdy0};
    assign rv  = {rv1, rv0};

    always #5 clk = ~clk;

    // Reference semantics: bit 32 is the error flag, low bits the result.
    function automatic logic [32:0] ref_op(logic [4:0] op, logic [31:0] x, logic [31:0] y);
        case (op)
            5'b00000: return {1'b0, x & y};
            5'b00001: return {1'b0, x | y};
            5'b00010: return {1'b0, x + y};
            5'b00110: return {1'b0, x - y};
            5'b00111: return {1'b0, 31'd0, ($signed(x) < $signed(y))};
            default:  return {1'b1, 32'd0};
        endcase
    endfunction

    // External ALU stand-in; drives garbage for illegal codes.
    function automatic logic [31:0] alu_model(logic [4:0] op, logic [31:0] x, logic [31:0] y);
        logic [32:0] t;
        t = ref_op(op, x, y);
        return t[32] ? 32'hDEADBEEF : t[31:0];
    endfunction

    assign alu_r = alu_model(alu_c, alu_a, alu_b);

    alu_arbiter #(.DATA_W(32), .CTRL_W(5)) dut (
        .iClk(clk), .iRst(rst),
        .iReqValid0(v[0]), .iReqValid1(v[1]),
        .oReqReady0(rdy0), .oReqReady1(rdy1),
        .iReqControl0(c[0]), .iReqControl1(c[1]),
        .iReqA0(a[0]), .iReqA1(a[1]), .iReqB0(b[0]), .iReqB1(b[1]),
        .oRspValid0(rv0), .oRspValid1(rv1),
        .iRspReady0(rr[0]), .iRspReady1(rr[1]),
        .oRspResult0(res0), .oRspResult1(res1),
        .oRspErr0(e0), .oRspErr1(e1),
        .oAluControl(alu_c), .oAluA(alu_a), .oAluB(alu_b),
        .iAluResult(alu_r), .oBusy(busy)
    );

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] res_of(int r);
        return (r == 1) ? res1 : res0;
    endfunction

    function automatic logic err_of(int r);
        return (r == 1) ? e1 : e0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        v   = 2'b00;
        rr  = 2'b11;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Single op on requester r; starts and ends just after a rising edge.
    task automatic do_op(int r, logic [4:0] op, logic [31:0] x, logic [31:0] y,
                         logic [31:0] eres, logic eerr, string nm);
        int n;
        logic [1:0] one;
        one  = (r == 1) ? 2'b10 : 2'b01;
        v[r] = 1'b1; c[r] = op; a[r] = x; b[r] = y;
        n = 0;
        @(negedge clk);
        while (rdy !== one && n < 20) begin
            tick(); @(negedge clk); n++;
        end
        chk({nm, "_rdy"}, 32'(rdy), 32'(one));
        tick();
        v[r] = 1'b0; a[r] = $urandom; b[r] = $urandom;
        @(negedge clk);
        chk({nm, "_aluctl"}, 32'(alu_c), 32'(op));
        chk({nm, "_exec_rv"}, 32'(rv), 32'd0);
        tick();
        @(negedge clk);
        chk({nm, "_rv"}, 32'(rv), 32'(one));
        chk({nm, "_res"}, res_of(r), eres);
        chk({nm, "_err"}, 32'(err_of(r)), 32'(eerr));
        tick();
        @(negedge clk);
        chk({nm, "_idle"}, {30'd0, busy, |rv}, 32'd0);
        tick();
    endtask

    typedef struct {
        int          r;
        logic [4:0]  op;
        logic [31:0] x, y, res;
        logic        err;
        string       nm;
    } vec_t;

    vec_t        tbl [11];
    logic [4:0]  legal_ops [5];
    bit          out, acc_flag [2];
    int          own, acc_cyc, last, cyc, n;
    logic [32:0] expv;
    logic [1:0]  exp_rdy;

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{0, 5'b00010, 32'd5,        32'd7,        32'd12,       1'b0, "add57"};
        tbl[1]  = '{1, 5'b00010, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, "addovf"};
        tbl[2]  = '{0, 5'b00000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, "and"};
        tbl[3]  = '{1, 5'b00001, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, "or"};
        tbl[4]  = '{0, 5'b00110, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, "sub35"};
        tbl[5]  = '{1, 5'b00111, 32'hFFFFFFFF, 32'd2,        32'd1,        1'b0, "slt_t"};
        tbl[6]  = '{0, 5'b00111, 32'd2,        32'hFFFFFFFF, 32'd0,        1'b0, "slt_f"};
        tbl[7]  = '{1, 5'b01000, 32'd9,        32'd9,        32'd0,        1'b1, "ill8"};
        tbl[8]  = '{1, 5'b00010, 32'd1,        32'd1,        32'd2,        1'b0, "after_ill"};
        tbl[9]  = '{0, 5'b11111, 32'd4,        32'd4,        32'd0,        1'b1, "ill31"};
        tbl[10] = '{0, 5'b00110, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, "subwrap"};
        legal_ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00110, 5'b00111};
        for (int i = 0; i < 2; i++) begin c[i] = '0; a[i] = '0; b[i] = '0; end

        // Reset values, both during and just after reset.
        rst = 1'b1; v = 2'b00; rr = 2'b11;
        #12;
        chk("rst_outs", {rdy, rv, e1, e0, busy}, 32'd0);
        chk("rst_alu", {alu_c, alu_a[26:0] | alu_b[26:0]}, 32'd0);
        do_reset();
        @(negedge clk);
        chk("post_rst", {res0 | res1}, 32'd0);
        tick();

        for (int i = 0; i < 11; i++)
            do_op(tbl[i].r, tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].res, tbl[i].err, tbl[i].nm);

        // Both requesters always valid: grants alternate, starting with 0 after reset.
        do_reset();
        tick();
        v = 2'b11;
        c[0] = 5'b00110; a[0] = 32'd3;          b[0] = 32'd5;
        c[1] = 5'b00111; a[1] = 32'hFFFFFFFF;   b[1] = 32'd2;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            @(negedge clk);
            while (rdy == 2'b00 && n < 10) begin tick(); @(negedge clk); n++; end
            chk("rr_grant", 32'(rdy), (k % 2) ? 32'd2 : 32'd1);
            if (k > 0) chk("rr_b2b_wait", n, 0);
            tick(); @(negedge clk); tick(); @(negedge clk);
            chk("rr_rv", 32'(rv), (k % 2) ? 32'd2 : 32'd1);
            chk("rr_res", res_of(k % 2), (k % 2) ? 32'd1 : 32'hFFFFFFFE);
            tick();
        end
        v = 2'b00;
        tick(); tick();

        // Backpressure on requester 1 while requester 0 waits.
        v[1] = 1'b1; c[1] = 5'b00010; a[1] = 32'd10; b[1] = 32'd20;
        @(negedge clk);
        chk("bp_rdy1", 32'(rdy), 32'd2);
        tick();
        v[1] = 1'b0; rr[1] = 1'b0;
        v[0] = 1'b1; c[0] = 5'b00010; a[0] = 32'd1; b[0] = 32'd2;
        @(negedge clk);
        chk("bp_exec_rdy", 32'(rdy), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_hold", {rv, 2'b00, res1[27:0]}, {2'b10, 2'b00, 28'd30});
            chk("bp_rdy0", 32'(rdy), 32'd0);
            tick();
        end
        rr[1] = 1'b1;
        @(negedge clk);
        chk("bp_hs_rdy", {30'd0, rv}, 32'd2);
        tick();
        @(negedge clk);
        chk("bp_accept", 32'(rdy), 32'd1);
        tick();
        v[0] = 1'b0;
        tick();
        @(negedge clk);
        chk("bp_res0", {rv, res0[29:0]}, {2'b01, 30'd3});
        tick(); tick();

        // Asynchronous reset in EXEC discards the op; first grant then goes to 0.
        v[0] = 1'b1; c[0] = 5'b00010; a[0] = 32'd4; b[0] = 32'd4;
        @(negedge clk);
        chk("ar_rdy0", 32'(rdy), 32'd1);
        tick();
        v[0] = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("ar_busy", {30'd0, busy, |rv}, 32'd0);
        chk("ar_alu", alu_a | alu_b | 32'(alu_c), 32'd0);
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ar_no_rsp", 32'(rv), 32'd0);
            tick();
        end
        v = 2'b11;
        @(negedge clk);
        chk("ar_first_grant", 32'(rdy), 32'd1);
        tick();
        v = 2'b00;
        tick(); tick(); tick();

        // Random traffic against the transaction model.
        do_reset();
        tick();
        out = 0; last = 1; cyc = 0; own = 0; acc_cyc = 0; expv = '0;
        acc_flag[0] = 0; acc_flag[1] = 0;
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (acc_flag[i]) begin v[i] = 1'b0; acc_flag[i] = 0; end
                else if (v[i] && $urandom_range(0, 15) == 0) v[i] = 1'b0;
                else if (!v[i] && $urandom_range(0, 2) == 0) begin
                    v[i] = 1'b1;
                    n = $urandom_range(0, 5);
                    c[i] = (n == 5) ? 5'($urandom) : legal_ops[n];
                    a[i] = $urandom; b[i] = $urandom;
                end
            end
            rr = 2'($urandom_range(0, 3));
            @(negedge clk);
            if (!out) begin
                case (v)
                    2'b00:   exp_rdy = 2'b00;
                    2'b01:   exp_rdy = 2'b01;
                    2'b10:   exp_rdy = 2'b10;
                    default: exp_rdy = (last == 1) ? 2'b01 : 2'b10;
                endcase
                chk("rnd_rdy", 32'(rdy), 32'(exp_rdy));
                chk("rnd_idle_rv", 32'(rv), 32'd0);
                if (exp_rdy != 2'b00) begin
                    own = exp_rdy[1] ? 1 : 0;
                    out = 1; acc_cyc = cyc; last = own; acc_flag[own] = 1;
                    expv = ref_op(c[own], a[own], b[own]);
                end
            end else begin
                chk("rnd_busy_rdy", 32'(rdy), 32'd0);
                if (cyc >= acc_cyc + 2) begin
                    chk("rnd_rv", 32'(rv), (own == 1) ? 32'd2 : 32'd1);
                    chk("rnd_res", res_of(own), expv[31:0]);
                    chk("rnd_err", 32'(err_of(own)), 32'(expv[32]));
                    if (rr[own]) out = 0;
                end else begin
                    chk("rnd_exec_rv", 32'(rv), 32'd0);
                end
            end
            cyc++;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
